rc4: RTL and testbench



---
 rtl/rc4_pkg.sv | 23 ++
 rtl/rc4_sbox.sv | 35 +++
 rtl/rc4.sv | 141 ++++++++++++++
 tb/tb_rc4.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and constants for the rc4 keystream generator
package rc4_pkg;

    localparam int SBOX_SIZE = 256;
    localparam int BYTE_W    = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_KSA,
        ST_DROP,
        ST_PRGA
    } state_e;

    // Largest of three sizes; sizes the shared load/schedule/drop counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rc4_sbox.sv
// rtl/rc4_sbox.sv - 256x8 S-box registers with identity reset, three reads and a same-cycle swap
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  swap_en_i,
    input  byte_t addr_a_i,
    input  byte_t addr_b_i,
    input  byte_t addr_c_i,
    output byte_t data_a_o,
    output byte_t data_b_o,
    output byte_t data_c_o
);

    byte_t mem_q [SBOX_SIZE];

    // Reads are pre-swap values; port c feeds the post-swap keystream lookup
    assign data_a_o = mem_q[addr_a_i];
    assign data_b_o = mem_q[addr_b_i];
    assign data_c_o = mem_q[addr_c_i];

    // Identity fill on reset, otherwise exchange entries a and b (a==b leaves S unchanged)
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int n = 0; n < SBOX_SIZE; n++) begin
                mem_q[n] <= BYTE_W'(n);
            end
        end else if (swap_en_i) begin
            mem_q[addr_a_i] <= data_b_o;
            mem_q[addr_b_i] <= data_a_o;
        end
    end

endmodule

// File: rtl/rc4.sv
// rtl/rc4.sv - RC4 keystream generator (serial key load, KSA, PRGA); optional RC4_DROP_EN discards DROP_BYTES
module rc4
    import rc4_pkg::*;
#(
    parameter int KEY_SIZE   = 7,
    parameter int DROP_BYTES = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] password_input,
    output logic       output_ready,
    output logic [7:0] K
);

    localparam int CNT_MAX = max3(KEY_SIZE, SBOX_SIZE, DROP_BYTES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int KIDX_W  = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_SIZE - 1);
`ifdef RC4_DROP_EN
    localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_BYTES - 1);
`endif

    state_e           state_q;
    byte_t            i_q;
    byte_t            j_q;
    logic [CNT_W-1:0] cnt_q;
    byte_t            key_q [KEY_SIZE];
    byte_t            k_q;
    logic             ready_q;

    byte_t key_byte;
    byte_t prga_i_d;
    byte_t prga_j_d;
    byte_t ksa_j_d;
    byte_t k_d;
    byte_t addr_a;
    byte_t addr_b;
    byte_t addr_c;
    byte_t s_a;
    byte_t s_b;
    byte_t s_c;
    logic  swap_en;

    // Index arithmetic; during KSA the counter doubles as i mod KEY_SIZE
    assign key_byte = key_q[cnt_q[KIDX_W-1:0]];
    assign prga_i_d = i_q + 8'd1;
    assign addr_a   = (state_q == ST_KSA) ? i_q : prga_i_d;
    assign ksa_j_d  = j_q + s_a + key_byte;
    assign prga_j_d = j_q + s_a;
    assign addr_b   = (state_q == ST_KSA) ? ksa_j_d : prga_j_d;
    assign addr_c   = s_a + s_b;
    assign swap_en  = (state_q != ST_LOAD);

    // Output byte as seen after this edge's swap: forward the swapped pair when t hits i' or j'
    assign k_d = (addr_c == prga_i_d) ? s_b :
                 (addr_c == prga_j_d) ? s_a : s_c;

    rc4_sbox u_sbox (
        .clk       (clk),
        .rst       (rst),
        .swap_en_i (swap_en),
        .addr_a_i  (addr_a),
        .addr_b_i  (addr_b),
        .addr_c_i  (addr_c),
        .data_a_o  (s_a),
        .data_b_o  (s_b),
        .data_c_o  (s_c)
    );

    // Capture one key byte per edge while loading
    always_ff @(posedge clk) begin
        if (rst && state_q == ST_LOAD) begin
            key_q[cnt_q[KIDX_W-1:0]] <= password_input;
        end
    end

    // Phase sequencing, indices and registered keystream output
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (cnt_q == KEY_LAST) begin
                        state_q <= ST_KSA;
                        cnt_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_KSA: begin
                    i_q   <= i_q + 8'd1;
                    j_q   <= ksa_j_d;
                    cnt_q <= (cnt_q == KEY_LAST) ? '0 : cnt_q + CNT_W'(1);
                    if (i_q == 8'hff) begin
`ifdef RC4_DROP_EN
                        state_q <= ST_DROP;
`else
                        state_q <= ST_PRGA;
`endif
                        i_q   <= '0;
                        j_q   <= '0;
                        cnt_q <= '0;
                    end
                end
`ifdef RC4_DROP_EN
                ST_DROP: begin
                    i_q <= prga_i_d;
                    j_q <= prga_j_d;
                    if (cnt_q == DROP_LAST) begin
                        state_q <= ST_PRGA;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                ST_PRGA: begin
                    i_q     <= prga_i_d;
                    j_q     <= prga_j_d;
                    k_q     <= k_d;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign output_ready = ready_q;
    assign K            = k_q;

endmodule

// File: tb/tb_rc4.sv
// tb/tb_rc4.sv - directed bench for rc4 (KEY_SIZE 7 and 5 instances, optional RC4_DROP_EN build)
module tb_rc4;

`ifdef RC4_DROP_EN
    localparam int LAT7 = 264 + 256;
    localparam int LAT5 = 262 + 256;
`else
    localparam int LAT7 = 264;
    localparam int LAT5 = 262;
`endif
    localparam int CAP  = LAT7 + 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] password_input = 8'h00;
    logic       rdy7;
    logic       rdy5;
    logic [7:0] k7o;
    logic [7:0] k5o;

    logic [7:0] exp7 [16] = '{8'h29, 8'h3f, 8'h02, 8'hd4, 8'h7f, 8'h37, 8'hc9, 8'hb6,
                              8'h33, 8'hf2, 8'haf, 8'h52, 8'h85, 8'hfe, 8'hb4, 8'h6b};
    logic [7:0] exp5 [8]  = '{8'hb2, 8'h39, 8'h63, 8'h05, 8'hf0, 8'h3d, 8'hc0, 8'h27};

    int checks = 0;
    int errors = 0;

    rc4 #(.KEY_SIZE(7)) dut7 (
        .clk            (clk),
        .rst            (rst),
        .password_input (password_input),
        .output_ready   (rdy7),
        .K              (k7o)
    );

    rc4 #(.KEY_SIZE(5)) dut5 (
        .clk            (clk),
        .rst            (rst),
        .password_input (password_input),
        .output_ready   (rdy5),
        .K              (k5o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

`ifdef RC4_DROP_EN
    // Reference keystream byte at offset idx for key 01,02,..,klen
    function automatic logic [7:0] rc4_ref(input int klen, input int idx);
        logic [7:0] s [256];
        logic [7:0] i, j, t;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 8'h00;
        for (int n = 0; n < 256; n++) begin
            j = j + s[n] + 8'((n % klen) + 1);
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 8'h00; j = 8'h00; t = 8'h00;
        for (int c = 0; c <= idx; c++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[8'(s[i] + s[j])];
        end
        return t;
    endfunction
`endif

    // Release from reset, feed the key one byte per edge (junk afterwards), record and check
    task automatic run_and_check(input string tag);
        logic       r7 [CAP+1];
        logic       r5 [CAP+1];
        logic [7:0] k7 [CAP+1];
        logic [7:0] k5 [CAP+1];
        int quiet7;
        int quiet5;
        quiet7 = 0;
        quiet5 = 0;
        rst = 1'b1;
        for (int e = 1; e <= CAP; e++) begin
            password_input = (e <= 7) ? 8'(e) : 8'(8'hc3 ^ 8'(e));
            step();
            r7[e] = rdy7; k7[e] = k7o;
            r5[e] = rdy5; k5[e] = k5o;
        end
        for (int e = 1; e < LAT7; e++) if (r7[e] !== 1'b0 || k7[e] !== 8'h00) quiet7++;
        for (int e = 1; e < LAT5; e++) if (r5[e] !== 1'b0 || k5[e] !== 8'h00) quiet5++;
        check({tag, "_quiet7"}, quiet7, 0);
        check({tag, "_quiet5"}, quiet5, 0);
        check({tag, "_rdy7_before"}, r7[LAT7-1], 0);
        check({tag, "_rdy7_first"},  r7[LAT7],   1);
        check({tag, "_rdy5_before"}, r5[LAT5-1], 0);
        check({tag, "_rdy5_first"},  r5[LAT5],   1);
`ifdef RC4_DROP_EN
        for (int n = 0; n < 4; n++) begin
            check($sformatf("%s_k7_%0d", tag, n), k7[LAT7+n], rc4_ref(7, 256 + n));
            check($sformatf("%s_k5_%0d", tag, n), k5[LAT5+n], rc4_ref(5, 256 + n));
        end
`else
        for (int n = 0; n < 16; n++) check($sformatf("%s_k7_%0d", tag, n), k7[LAT7+n], exp7[n]);
        for (int n = 0; n < 8; n++)  check($sformatf("%s_k5_%0d", tag, n), k5[LAT5+n], exp5[n]);
`endif
    endtask

    initial begin
        int drops;

        // Reset held with toggling key input: outputs stay quiet
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            password_input = c[0] ? 8'h5a : 8'ha5;
            step();
            check($sformatf("rst_hold_rdy7_%0d", c), rdy7, 0);
            check($sformatf("rst_hold_k7_%0d", c),   k7o,  8'h00);
            check($sformatf("rst_hold_rdy5_%0d", c), rdy5, 0);
            check($sformatf("rst_hold_k5_%0d", c),   k5o,  8'h00);
        end

        run_and_check("run1");

        // output_ready must never drop once raised
        drops = 0;
        for (int c = CAP; c < 2000; c++) begin
            step();
            if (rdy7 !== 1'b1 || rdy5 !== 1'b1) drops++;
        end
        check("ready_stays", drops, 0);

        // Mid-PRGA reset aborts; same key restarts identical sequence with same latency
        rst = 1'b0;
        password_input = 8'h33;
        step();
        check("midrst_rdy7", rdy7, 0);
        check("midrst_k7",   k7o,  8'h00);
        check("midrst_rdy5", rdy5, 0);
        check("midrst_k5",   k5o,  8'h00);

        run_and_check("run2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
